rank_access_sequencer: RTL and testbench

//  Upstream command stage for the dual-rank memory. Takes one request at a time over a

---
 rtl/rank_access_sequencer.sv | 111 +++++++++++
 tb/tb_rank_access_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rank_access_sequencer.sv
// Single-outstanding command sequencer for the dual-rank memory: decodes the rank,
// holds the shared rank buses for the rank timing, and returns read data on a response port.
module rank_access_sequencer #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LAT     = 3,
  parameter int WR_CYCLES  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-2:0] rank_addr,
  output logic [DATA_WIDTH-1:0] rank_din,
  output logic                  rank_wr,
  output logic [1:0]            rank_be,
  input  logic [DATA_WIDTH-1:0] rank0_dout,
  input  logic [DATA_WIDTH-1:0] rank1_dout,
  output logic                  busy
);

  localparam int MSB   = ADDR_WIDTH - 1;
  localparam int MAXC  = (RD_LAT > WR_CYCLES) ? RD_LAT : WR_CYCLES;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             wrReg;
  logic             rankReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wrReg     <= 1'b0;
      rankReg   <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rank_addr <= '0;
      rank_din  <= '0;
      rank_wr   <= 1'b0;
      rank_be   <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // req_ready is always high here, so req_valid alone is the handshake
          if (req_valid) begin
            wrReg     <= req_wr;
            rankReg   <= req_addr[MSB];
            cnt       <= '0;
            state     <= ACCESS;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            rank_be   <= req_addr[MSB] ? 2'b10 : 2'b01;
            rank_addr <= req_addr[MSB-1:0];
            rank_din  <= req_wdata;
            rank_wr   <= req_wr;
          end
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          if (cnt == (wrReg ? WR_LAST : RD_LAST)) begin
            state   <= RECOVER;
            rank_be <= '0;
            rank_wr <= 1'b0;
          end
        end
        RECOVER: begin
          if (wrReg) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            rsp_rdata <= rankReg ? rank1_dout : rank0_dout;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            rsp_valid <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          rank_be   <= '0;
          rank_wr   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rank_access_sequencer.sv
// Directed bench for rank_access_sequencer with a two-rank memory model
// (cs register + RAM + dataOut register) behind the shared buses.
module tb_rank_access_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_wr = 1'b0;
  logic [9:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_rdata;
  logic [8:0] rank_addr;
  logic [7:0] rank_din;
  logic       rank_wr;
  logic [1:0] rank_be;
  logic [7:0] rank0_dout = '0;
  logic [7:0] rank1_dout = '0;
  logic       busy;

  int nChecks = 0;
  int nErrors = 0;

  rank_access_sequencer #(
    .ADDR_WIDTH(10),
    .DATA_WIDTH(8),
    .RD_LAT    (3),
    .WR_CYCLES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rank_addr (rank_addr),
    .rank_din  (rank_din),
    .rank_wr   (rank_wr),
    .rank_be   (rank_be),
    .rank0_dout(rank0_dout),
    .rank1_dout(rank1_dout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  logic [7:0] mem0 [512];
  logic [7:0] mem1 [512];
  logic       cs0Q = 1'b0, cs1Q = 1'b0, wrQ = 1'b0;
  logic [8:0] aQ = '0;
  logic [7:0] dQ = '0, ramOut0 = '0, ramOut1 = '0;

  always @(posedge clk) begin
    cs0Q <= rank_be[0];
    cs1Q <= rank_be[1];
    wrQ  <= rank_wr;
    aQ   <= rank_addr;
    dQ   <= rank_din;
    if (cs0Q) begin
      if (wrQ) mem0[aQ] <= dQ;
      else     ramOut0  <= mem0[aQ];
    end
    if (cs1Q) begin
      if (wrQ) mem1[aQ] <= dQ;
      else     ramOut1  <= mem1[aQ];
    end
    rank0_dout <= ramOut0;
    rank1_dout <= ramOut1;
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one request and follows it until req_ready (write) or rsp_valid (read).
  task automatic runReq(input string tag, input logic wr, input logic [9:0] addr,
                        input logic [7:0] wdata, input logic [1:0] expBe,
                        input int expLat, input int expBeCyc, output logic [7:0] rdata);
    int lat, beCyc, wrCyc, bad;
    bit done;
    lat = 99; beCyc = 0; wrCyc = 0; bad = 0; done = 0; rdata = '0;
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
    checkVal({tag, ".acceptReady"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkVal({tag, ".busy"}, 32'(busy), 32'd1);
    for (int c = 0; c < 20 && !done; c++) begin
      if (rank_be != 2'b00) begin
        beCyc++;
        if (rank_be !== expBe || rank_addr !== addr[8:0] || (wr && rank_din !== wdata)) bad++;
      end
      if (rank_wr) begin
        wrCyc++;
        if (rank_be == 2'b00 || !wr) bad++;
      end
      if (wr ? req_ready : rsp_valid) begin
        done = 1;
        lat  = c;
      end else begin
        @(posedge clk); #1;
      end
    end
    checkVal({tag, ".latency"}, 32'(lat), 32'(expLat));
    checkVal({tag, ".beCycles"}, 32'(beCyc), 32'(expBeCyc));
    checkVal({tag, ".wrCycles"}, 32'(wrCyc), wr ? 32'(expBeCyc) : 32'd0);
    checkVal({tag, ".busViolations"}, 32'(bad), 32'd0);
    if (!wr) begin
      rdata = rsp_rdata;
      if (rsp_ready) begin
        @(posedge clk); #1;
        checkVal({tag, ".rspClear"}, 32'(rsp_valid), 32'd0);
        checkVal({tag, ".readyBack"}, 32'(req_ready), 32'd1);
      end
    end
  endtask

  initial begin
    logic [7:0] rd;
    int rises;

    repeat (3) @(posedge clk);
    #1;
    checkVal("rst.req_ready", 32'(req_ready), 32'd1);
    checkVal("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    checkVal("rst.rank_be", 32'(rank_be), 32'd0);
    checkVal("rst.rank_wr", 32'(rank_wr), 32'd0);
    checkVal("rst.busy", 32'(busy), 32'd0);
    checkVal("rst.rsp_rdata", 32'(rsp_rdata), 32'd0);
    checkVal("rst.rank_addr", 32'(rank_addr), 32'd0);
    rst = 1'b0;

    runReq("wr2A5", 1'b1, 10'h2A5, 8'h5A, 2'b10, 3, 2, rd);
    runReq("rd2A5", 1'b0, 10'h2A5, 8'h00, 2'b10, 5, 3, rd);
    checkVal("rd2A5.data", 32'(rd), 32'h5A);

    runReq("wr005", 1'b1, 10'h005, 8'h11, 2'b01, 3, 2, rd);
    runReq("wr205", 1'b1, 10'h205, 8'h22, 2'b10, 3, 2, rd);
    runReq("rd005", 1'b0, 10'h005, 8'h00, 2'b01, 5, 3, rd);
    checkVal("rd005.data", 32'(rd), 32'h11);
    runReq("rd205", 1'b0, 10'h205, 8'h00, 2'b10, 5, 3, rd);
    checkVal("rd205.data", 32'(rd), 32'h22);

    runReq("wr3FF", 1'b1, 10'h3FF, 8'hC3, 2'b10, 3, 2, rd);
    runReq("wr000", 1'b1, 10'h000, 8'h3C, 2'b01, 3, 2, rd);
    runReq("rd3FF", 1'b0, 10'h3FF, 8'h00, 2'b10, 5, 3, rd);
    checkVal("rd3FF.data", 32'(rd), 32'hC3);
    runReq("rd000", 1'b0, 10'h000, 8'h00, 2'b01, 5, 3, rd);
    checkVal("rd000.data", 32'(rd), 32'h3C);

    rsp_ready = 1'b0;
    runReq("bpRd", 1'b0, 10'h2A5, 8'h00, 2'b10, 5, 3, rd);
    checkVal("bpRd.data", 32'(rd), 32'h5A);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 10'h005;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkVal("bp.rsp_valid", 32'(rsp_valid), 32'd1);
      checkVal("bp.rsp_rdata", 32'(rsp_rdata), 32'h5A);
      checkVal("bp.req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checkVal("bp.rspClear", 32'(rsp_valid), 32'd0);
    checkVal("bp.readyBack", 32'(req_ready), 32'd1);
    runReq("bpNext", 1'b0, 10'h005, 8'h00, 2'b01, 5, 3, rd);
    checkVal("bpNext.data", 32'(rd), 32'h11);

    req_valid = 1'b1; req_wr = 1'b0; req_addr = 10'h2A5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkVal("abort.be", 32'(rank_be), 32'h2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkVal("abort.rank_be", 32'(rank_be), 32'd0);
    checkVal("abort.req_ready", 32'(req_ready), 32'd1);
    checkVal("abort.busy", 32'(busy), 32'd0);
    rises = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid) rises++;
      @(posedge clk); #1;
    end
    checkVal("abort.noRsp", 32'(rises), 32'd0);
    runReq("rdAfterAbort", 1'b0, 10'h205, 8'h00, 2'b10, 5, 3, rd);
    checkVal("rdAfterAbort.data", 32'(rd), 32'h22);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
